sync_fifo_flags: RTL and testbench

// Single-clock, parametrised FIFO for same-domain buffering beside the ASYNC_FIFO.

---
 rtl/sync_fifo_flags_if.sv | 29 ++
 rtl/sync_fifo_flags.sv | 90 +++++++++
 tb/tb_sync_fifo_flags.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Bus interface for sync_fifo_flags: write side, read side, flush, and status.
// The master drives requests and data. The slave (the FIFO) drives read data and flags.
interface sync_fifo_flags_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] wData;
  logic                  winc;
  logic                  wFull;
  logic                  wAlmostFull;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rData;
  logic                  rEmpty;
  logic                  rAlmostEmpty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wData, winc, rinc,
    input  wFull, wAlmostFull, rData, rEmpty, rAlmostEmpty, count, overflow, underflow
  );

  modport slave (
    input  flush, wData, winc, rinc,
    output wFull, wAlmostFull, rData, rEmpty, rAlmostEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO that provides an exact fill count and programmable almost-full and almost-empty flags.
// It also provides sticky overflow and underflow flags, a synchronous flush, and an optional
// first-word-fall-through read path. All flags decode from the registered count.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2,
  parameter bit          FWFT       = 1'b0
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_flags_if.slave  bus
);
  localparam int unsigned         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A flush cycle ignores both requests.
  // A full FIFO still accepts a read, and an empty FIFO still accepts a write.
  assign w_wr_acc = bus.winc && !w_full  && !bus.flush;
  assign w_rd_acc = bus.rinc && !w_empty && !bus.flush;

  assign bus.wFull        = w_full;
  assign bus.rEmpty       = w_empty;
  assign bus.wAlmostFull  = (r_count >= C_AF);
  assign bus.rAlmostEmpty = (r_count <= C_AE);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Pointers, fill count, and sticky error flags; flush returns these to their reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + ADDR_WIDTH'(1);
      if (w_rd_acc) r_rptr <= r_rptr + ADDR_WIDTH'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + (ADDR_WIDTH+1)'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - (ADDR_WIDTH+1)'(1);
      if (bus.winc && w_full)  r_overflow  <= 1'b1;
      if (bus.rinc && w_empty) r_underflow <= 1'b1;
    end
  end

  // Storage array; it is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= bus.wData;
  end

  if (FWFT) begin : g_fwft
    assign bus.rData = r_mem[r_rptr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_rdata;

    // Registered read port; it holds its last value when no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_rdata <= '0;
      else if (w_rd_acc) r_rdata <= r_mem[r_rptr];
    end

    assign bus.rData = r_rdata;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed testbench for sync_fifo_flags.
// It exercises a registered-read instance and a first-word-fall-through instance.
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass   = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_a ();
  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_b ();

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    bit       winc;
    bit       rinc;
    bit       flush;
    logic [7:0] wdata;
    int       cnt;
    int       rd;
    bit       full;
    bit       af;
    bit       empty;
    bit       ae;
    bit       ovf;
    bit       udf;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc_a(input bit w, input bit r, input bit f, input logic [7:0] d);
    bus_a.winc = w; bus_a.rinc = r; bus_a.flush = f; bus_a.wData = d;
    @(posedge clk); #1;
    bus_a.winc = 1'b0; bus_a.rinc = 1'b0; bus_a.flush = 1'b0;
  endtask

  task automatic cyc_b(input bit w, input bit r, input logic [7:0] d);
    bus_b.winc = w; bus_b.rinc = r; bus_b.flush = 1'b0; bus_b.wData = d;
    @(posedge clk); #1;
    bus_b.winc = 1'b0; bus_b.rinc = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int cnt, input int rd, input bit full, input bit af,
                       input bit empty, input bit ae, input bit ovf, input bit udf);
    check({tag, "_count"}, 32'(bus_a.count), cnt);
    check({tag, "_rData"}, 32'(bus_a.rData), rd);
    check({tag, "_wFull"}, 32'(bus_a.wFull), 32'(full));
    check({tag, "_wAF"},   32'(bus_a.wAlmostFull), 32'(af));
    check({tag, "_rEmpty"}, 32'(bus_a.rEmpty), 32'(empty));
    check({tag, "_rAE"},   32'(bus_a.rAlmostEmpty), 32'(ae));
    check({tag, "_ovf"},   32'(bus_a.overflow), 32'(ovf));
    check({tag, "_udf"},   32'(bus_a.underflow), 32'(udf));
  endtask

  initial begin
    byte unsigned q[$];
    byte unsigned exp_rd;
    bit do_w;
    logic [7:0] wd;

    bus_a.winc = 1'b0; bus_a.rinc = 1'b0; bus_a.flush = 1'b0; bus_a.wData = '0;
    bus_b.winc = 1'b0; bus_b.rinc = 1'b0; bus_b.flush = 1'b0; bus_b.wData = '0;

    //                winc  rinc  flush wdata  cnt rd     full  af    empty ae    ovf   udf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h44, 2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h66, 0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h77, 1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Power-on reset state
    #12 rst = 1'b1;
    #1;
    chk_a("reset", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Table-driven basic operation, underflow, flush
    foreach (vecs[i]) begin
      cyc_a(vecs[i].winc, vecs[i].rinc, vecs[i].flush, vecs[i].wdata);
      chk_a($sformatf("v%0d", i), vecs[i].cnt, vecs[i].rd, vecs[i].full, vecs[i].af,
            vecs[i].empty, vecs[i].ae, vecs[i].ovf, vecs[i].udf);
    end

    // Fill to full, overflow, concurrent request on full, drain in order
    for (int i = 0; i < 16; i++) begin
      cyc_a(1'b1, 1'b0, 1'b0, 8'(i));
      check($sformatf("fill%0d_count", i), 32'(bus_a.count), i + 1);
      check($sformatf("fill%0d_wAF", i), 32'(bus_a.wAlmostFull), 32'((i + 1) >= 14));
      check($sformatf("fill%0d_wFull", i), 32'(bus_a.wFull), 32'((i + 1) == 16));
    end
    cyc_a(1'b1, 1'b0, 1'b0, 8'hAA);
    chk_a("ovf", 16, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc_a(1'b1, 1'b1, 1'b0, 8'hBB);
    chk_a("full_wr_rd", 15, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("drain%0d_rData", i), 32'(bus_a.rData), i);
      check($sformatf("drain%0d_count", i), 32'(bus_a.count), 15 - i);
    end
    check("drain_empty", 32'(bus_a.rEmpty), 1);

    // Underflow leaves the read pointer alone
    cyc_a(1'b0, 1'b1, 1'b0, 8'h00);
    chk_a("udf", 0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc_a(1'b1, 1'b0, 1'b0, 8'h99);
    cyc_a(1'b0, 1'b1, 1'b0, 8'h00);
    check("udf_rptr_rData", 32'(bus_a.rData), 8'h99);
    cyc_a(1'b0, 1'b0, 1'b1, 8'h00);
    chk_a("flush_clr", 0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Concurrent read/write at count 5
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    check("conc_pre_count", 32'(bus_a.count), 5);
    for (int k = 0; k < 10; k++) begin
      cyc_a(1'b1, 1'b1, 1'b0, 8'(8'h25 + k));
      check($sformatf("conc%0d_rData", k), 32'(bus_a.rData), 8'h20 + k);
      check($sformatf("conc%0d_count", k), 32'(bus_a.count), 5);
    end
    for (int k = 0; k < 5; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("conc_drain%0d_rData", k), 32'(bus_a.rData), 8'h2A + k);
    end

    // Pointer wrap: 3 writes / 3 reads alternating against a queue model
    exp_rd = bus_a.rData;
    for (int i = 0; i < 80; i++) begin
      do_w = ((i / 3) % 2) == 0;
      wd   = 8'(i * 7 + 3);
      if (do_w) begin
        cyc_a(1'b1, 1'b0, 1'b0, wd);
        q.push_back(wd);
      end else begin
        cyc_a(1'b0, 1'b1, 1'b0, 8'h00);
        if (q.size() > 0) exp_rd = q.pop_front();
      end
      check($sformatf("wrap%0d_rData", i), 32'(bus_a.rData), 32'(exp_rd));
      check($sformatf("wrap%0d_count", i), 32'(bus_a.count), q.size());
      check($sformatf("wrap%0d_rAE", i), 32'(bus_a.rAlmostEmpty), 32'(q.size() <= 2));
    end

    // Asynchronous reset in the middle of traffic
    cyc_a(1'b1, 1'b0, 1'b0, 8'hC1);
    cyc_a(1'b1, 1'b1, 1'b0, 8'hC2);
    bus_a.winc = 1'b1; bus_a.wData = 8'hC3;
    #2 rst = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_a.winc = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk_a("post_rst", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // First-word-fall-through instance
    cyc_b(1'b1, 1'b0, 8'h5C);
    check("fwft_empty0", 32'(bus_b.rEmpty), 0);
    check("fwft_rData5C", 32'(bus_b.rData), 8'h5C);
    cyc_b(1'b1, 1'b0, 8'h3D);
    check("fwft_hold_rData", 32'(bus_b.rData), 8'h5C);
    check("fwft_count2", 32'(bus_b.count), 2);
    cyc_b(1'b0, 1'b1, 8'h00);
    check("fwft_pop_rData", 32'(bus_b.rData), 8'h3D);
    check("fwft_pop_empty", 32'(bus_b.rEmpty), 0);
    cyc_b(1'b0, 1'b1, 8'h00);
    check("fwft_last_empty", 32'(bus_b.rEmpty), 1);
    check("fwft_last_count", 32'(bus_b.count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
